// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-addressed memory; define LSU_MISALIGN_TRAP_EN to trap misaligned requests
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  output logic [31:0]       loadData,
  output logic              loadValid,
  output logic              misaligned,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  input  logic [31:0]       mem_readData
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_READ, RMW_WRITE} state_t;
  state_t state, state_n;
  logic [2:0] f3_q;
  logic [ADDR_W-1:0] addr_q, addr_in;
  logic [31:0] wdata_q, merged_q, merged_n, ld_ext, shifted, lane_mask;
  logic [4:0] sh;
  logic take, trap, sx;
  assign req_ready = state == IDLE;
  assign take = req_ready && req_valid && (MemRead || MemWrite);
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (funct3[1] && address[1:0] != 2'b00) || (funct3[1:0] == 2'b01 && address[0]);
  assign addr_in = address;
`else
  assign trap = 1'b0;
  assign addr_in = {address[ADDR_W-1:2], funct3[1] ? 2'b00 : {address[1], address[0] & ~funct3[0]}};
`endif
  // Word accesses always have sh=0, so shifted doubles as the full word
  assign sh = {addr_q[1:0], 3'b000};
  assign shifted = mem_readData >> sh;
  assign sx = ~f3_q[2];
  assign lane_mask = f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  always_comb begin
    ld_ext = f3_q[1] ? shifted
           : f3_q[0] ? {{16{sx & shifted[15]}}, shifted[15:0]}
           : {{24{sx & shifted[7]}}, shifted[7:0]};
    merged_n = (mem_readData & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);
    state_n = state == IDLE ? ((take && !trap) ? (MemWrite ? (funct3[1] ? STORE_W : RMW_READ) : LOAD) : IDLE)
            : state == RMW_READ ? RMW_WRITE
            : IDLE;
    mem_MemRead = state == LOAD || state == RMW_READ;
    mem_MemWrite = state == STORE_W || state == RMW_WRITE;
    mem_address = state == IDLE ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    mem_writeData = state == STORE_W ? wdata_q : state == RMW_WRITE ? merged_q : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      loadData <= 32'h0;
      loadValid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_n;
      loadValid <= state == LOAD;
      misaligned <= take && trap;
      if (state == LOAD) loadData <= ld_ext;
      if (state == RMW_READ) merged_q <= merged_n;
      if (take && !trap) begin
        f3_q <= funct3;
        addr_q <= addr_in;
        wdata_q <= writeData;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks against a byte-array reference model
module tb_load_store_unit;
  logic clk = 0, reset = 1, req_valid = 0, MemRead = 0, MemWrite = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] address = 0, writeData = 0;
  logic req_ready, loadValid, misaligned, mem_MemRead, mem_MemWrite;
  logic [31:0] loadData, mem_address, mem_writeData, mem_readData;
  logic [31:0] mem [16];
  logic [7:0] rb [64];
  int passed = 0, total = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .address(address),
    .writeData(writeData), .loadData(loadData), .loadValid(loadValid),
    .misaligned(misaligned), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;
  assign mem_readData = mem[mem_address[5:2]];
  always @(posedge clk) if (mem_MemWrite) mem[mem_address[5:2]] <= mem_writeData;

  function automatic int size_of(logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit is_mis(logic [2:0] f3, int a);
`ifdef LSU_MISALIGN_TRAP_EN
    return a % size_of(f3) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base_of(logic [2:0] f3, int a);
    return a - a % size_of(f3);
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, int a);
    int n = size_of(f3);
    int b = base_of(f3, a);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(rb[b + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(logic [2:0] f3, int a, logic [31:0] wd);
    int b = base_of(f3, a);
    for (int i = 0; i < size_of(f3); i++) rb[b + i] = wd[8 * i +: 8];
  endfunction

  function automatic logic [31:0] ref_word(int w);
    return {rb[4 * w + 3], rb[4 * w + 2], rb[4 * w + 1], rb[4 * w]};
  endfunction

  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int busy, output int lv_at, output logic [31:0] ld,
                        output logic mis, output logic mact, output logic abad);
    req_valid = 1; MemRead = rd; MemWrite = wr; funct3 = f3; address = a; writeData = wd;
    busy = 0; lv_at = 0; ld = 0; mis = 0; mact = 0; abad = 0;
    @(posedge clk); #1;
    req_valid = 0; MemRead = 0; MemWrite = 0;
    for (int c = 1; c <= 8; c++) begin
      if (loadValid) begin lv_at = c; ld = loadData; end
      mis = mis | misaligned;
      if (mem_MemRead || mem_MemWrite) begin
        mact = 1;
        abad = abad | (mem_address[1:0] != 2'b00);
      end
      if (req_ready) break;
      busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    total++; if (loadValid !== 1'b0) $display("FAIL reset_loadValid got %b want 0", loadValid); else passed++;
    total++; if (loadData !== 32'h0) $display("FAIL reset_loadData got %h want 0", loadData); else passed++;
    total++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %b want 0", misaligned); else passed++;
    total++; if ({mem_MemRead, mem_MemWrite} !== 2'b00) $display("FAIL reset_mem_en got %b want 00", {mem_MemRead, mem_MemWrite}); else passed++;
    total++; if (mem_address !== 32'h0) $display("FAIL reset_mem_address got %h want 0", mem_address); else passed++;
    reset = 0;
  endtask

  task automatic test_init;
    int busy, lv; logic [31:0] ld, wd; logic mis, mact, abad;
    for (int w = 0; w < 16; w++) begin
      wd = (w == 0) ? 32'h1234_5678 : (w == 1) ? 32'hABCD_EF00 : $urandom;
      run_op(0, 1, 3'b010, 32'(4 * w), wd, busy, lv, ld, mis, mact, abad);
      ref_store(3'b010, 4 * w, wd);
    end
    for (int w = 0; w < 16; w++) begin
      total++; if (mem[w] !== ref_word(w)) $display("FAIL init_word%0d got %h want %h", w, mem[w], ref_word(w)); else passed++;
    end
  endtask

  task automatic test_loads;
    int busy, lv; logic [31:0] ld; logic mis, mact, abad;
    logic [2:0] f3s [6] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b100, 3'b101};
    logic [31:0] as [6] = '{32'h3, 32'h1, 32'h2, 32'h6, 32'h6, 32'h6};
    logic [31:0] ex [6] = '{32'h0000_0012, 32'h0000_0056, 32'h0000_1234, 32'hFFFF_FFCD, 32'h0000_00CD, 32'h0000_ABCD};
    for (int i = 0; i < 6; i++) begin
      run_op(1, 0, f3s[i], as[i], 32'h0, busy, lv, ld, mis, mact, abad);
      total++; if (ld !== ex[i]) $display("FAIL load%0d_data got %h want %h", i, ld, ex[i]); else passed++;
      total++; if (lv !== 2) $display("FAIL load%0d_latency got %0d want 2", i, lv); else passed++;
      total++; if (busy !== 1) $display("FAIL load%0d_busy got %0d want 1", i, busy); else passed++;
    end
  endtask

  task automatic test_subword_stores;
    int busy, lv; logic [31:0] ld; logic mis, mact, abad;
    run_op(0, 1, 3'b000, 32'h1, 32'h0000_00AA, busy, lv, ld, mis, mact, abad);
    ref_store(3'b000, 1, 32'hAA);
    total++; if (mem[0] !== 32'h1234_AA78) $display("FAIL sb_word got %h want 1234aa78", mem[0]); else passed++;
    total++; if (busy !== 2) $display("FAIL sb_busy got %0d want 2", busy); else passed++;
    run_op(0, 1, 3'b001, 32'h2, 32'h0000_BEEF, busy, lv, ld, mis, mact, abad);
    ref_store(3'b001, 2, 32'hBEEF);
    total++; if (mem[0] !== 32'hBEEF_AA78) $display("FAIL sh_word got %h want beefaa78", mem[0]); else passed++;
    total++; if (busy !== 2) $display("FAIL sh_busy got %0d want 2", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int busy, lv; logic [31:0] ld; logic mis, mact, abad;
    run_op(0, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, busy, lv, ld, mis, mact, abad);
    ref_store(3'b010, 8, 32'hDEAD_BEEF);
    total++; if (busy !== 1) $display("FAIL sw_busy got %0d want 1", busy); else passed++;
    run_op(1, 0, 3'b010, 32'h8, 32'h0, busy, lv, ld, mis, mact, abad);
    total++; if (ld !== 32'hDEAD_BEEF) $display("FAIL b2b_lw got %h want deadbeef", ld); else passed++;
    run_op(1, 0, 3'b000, 32'h8, 32'h0, busy, lv, ld, mis, mact, abad);
    total++; if (ld !== 32'hFFFF_FFEF || lv !== 2) $display("FAIL b2b_lb got %h at %0d want ffffffef at 2", ld, lv); else passed++;
  endtask

  task automatic test_misaligned;
    int busy, lv; logic [31:0] ld; logic mis, mact, abad;
    run_op(1, 0, 3'b010, 32'h2, 32'h0, busy, lv, ld, mis, mact, abad);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (mis !== 1'b1) $display("FAIL mis_pulse got %b want 1", mis); else passed++;
    total++; if (mact !== 1'b0) $display("FAIL mis_mem_access got %b want 0", mact); else passed++;
    total++; if (lv !== 0 || busy !== 0) $display("FAIL mis_no_access lv %0d busy %0d want 0 0", lv, busy); else passed++;
    @(posedge clk); #1;
    total++; if (misaligned !== 1'b0) $display("FAIL mis_one_cycle got %b want 0", misaligned); else passed++;
`else
    total++; if (ld !== 32'hBEEF_AA78) $display("FAIL mis_forced_align got %h want beefaa78", ld); else passed++;
    total++; if (mis !== 1'b0) $display("FAIL mis_tied_zero got %b want 0", mis); else passed++;
    total++; if (abad !== 1'b0) $display("FAIL mis_mem_addr_low got %b want 0", abad); else passed++;
`endif
    total++; if (mem[0] !== ref_word(0)) $display("FAIL mis_mem_unchanged got %h want %h", mem[0], ref_word(0)); else passed++;
  endtask

  task automatic test_ignored;
    int busy, lv; logic [31:0] ld; logic mis, mact, abad;
    run_op(0, 0, 3'b010, 32'h4, 32'h1111_1111, busy, lv, ld, mis, mact, abad);
    total++; if (busy !== 0 || mact !== 1'b0 || lv !== 0) $display("FAIL ignored got busy %0d mact %b lv %0d want 0 0 0", busy, mact, lv); else passed++;
  endtask

  task automatic test_random;
    int busy, lv, a, k, b; logic [31:0] ld, wd, exp; logic mis, mact, abad, wr, em;
    logic [2:0] f3;
    logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] stf [3] = '{3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 7);
      wr = k >= 5;
      f3 = wr ? stf[k - 5] : ldf[k];
      a = $urandom_range(0, 63);
      wd = $urandom;
      em = is_mis(f3, a);
      exp = ref_load(f3, a);
      b = base_of(f3, a);
      run_op(!wr, wr, f3, 32'(a), wd, busy, lv, ld, mis, mact, abad);
      total++; if (mis !== em) $display("FAIL rnd%0d_mis got %b want %b", i, mis, em); else passed++;
      if (em) begin
        total++; if (mact !== 1'b0 || busy !== 0) $display("FAIL rnd%0d_trap got mact %b busy %0d want 0 0", i, mact, busy); else passed++;
      end else if (wr) begin
        ref_store(f3, a, wd);
        total++; if (mem[b / 4] !== ref_word(b / 4) || busy !== (f3[1] ? 1 : 2) || abad)
          $display("FAIL rnd%0d_store f3 %b a %0d got %h busy %0d want %h", i, f3, a, mem[b / 4], busy, ref_word(b / 4)); else passed++;
      end else begin
        total++; if (ld !== exp || lv !== 2 || abad)
          $display("FAIL rnd%0d_load f3 %b a %0d got %h at %0d want %h at 2", i, f3, a, ld, lv, exp); else passed++;
      end
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] m0;
    m0 = mem[0];
    req_valid = 1; MemWrite = 1; funct3 = 3'b000; address = 32'h0; writeData = 32'h55;
    @(posedge clk); #1;
    req_valid = 0; MemWrite = 0;
    total++; if (mem_MemRead !== 1'b1) $display("FAIL rmw_read_en got %b want 1", mem_MemRead); else passed++;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_rmw_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_MemWrite !== 1'b0 || loadValid !== 1'b0) $display("FAIL rst_rmw_idle got wr %b lv %b want 0 0", mem_MemWrite, loadValid); else passed++;
    @(posedge clk); #1;
    total++; if (mem[0] !== m0) $display("FAIL rst_rmw_mem got %h want %h", mem[0], m0); else passed++;
    req_valid = 1; MemWrite = 1; funct3 = 3'b010; address = 32'h10; writeData = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_valid = 0; MemWrite = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    ref_store(3'b010, 16, 32'h0BAD_F00D);
    total++; if (mem[4] !== 32'h0BAD_F00D) $display("FAIL rst_sw_commit got %h want 0badf00d", mem[4]); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_sw_ready got %b want 1", req_ready); else passed++;
  endtask

  initial begin
    test_reset;
    test_init;
    test_loads;
    test_subword_stores;
    test_back_to_back;
    test_misaligned;
    test_ignored;
    test_random;
    test_reset_midop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
